// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM host request queue.
//   - Default address split (row/col/bank) and data width.
//   - Sequencer state encoding.
//   - Request record {we, addr, wdata} at the default widths.
package sdram_pkg;

  localparam int ROW_WIDTH       = 13;
  localparam int COL_WIDTH       = 9;
  localparam int BANK_WIDTH      = 2;
  localparam int HADDR_WIDTH_DEF = ROW_WIDTH + COL_WIDTH + BANK_WIDTH;
  localparam int DATA_WIDTH_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic                      we;
    logic [HADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0]  wdata;
  } req_t;

endpackage

// File: rtl/sdram_req_fifo.sv
// Synchronous request FIFO with a combinational head view.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   push, wdata     - write an entry (ignored when full)
//   pop             - drop the head entry (ignored when empty)
//   rdata           - current head entry
//   level           - occupancy 0..DEPTH
//   full, empty     - occupancy flags
module sdram_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == FULL_COUNT);
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign level   = count_reg;
  // The sequencer must see the head in the same cycle it decides to pop.
  assign rdata   = mem[rd_ptr_reg];

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  // Power-of-2 depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/sdram_host_queue.sv
// Host-side request queue and issue sequencer in front of the SDRAM controller.
// Ports:
//   clk, rst_n                        - clock, asynchronous active-low reset
//   req_valid/req_ready/req_we/
//   req_addr/req_wdata                - host request channel
//   rsp_valid/rsp_ready/rsp_rdata     - read response channel
//   haddr/data_input/rd_enable/
//   wr_enable                         - registered command to the controller
//   busy/data_output                  - controller status and read data
//   level                             - request FIFO occupancy
//   idle                              - nothing queued, in flight or pending
module sdram_host_queue
  import sdram_pkg::*;
#(
  parameter int HADDR_WIDTH = HADDR_WIDTH_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [HADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic [HADDR_WIDTH-1:0]   haddr,
  output logic [DATA_WIDTH-1:0]    data_input,
  output logic                     rd_enable,
  output logic                     wr_enable,
  input  logic                     busy,
  input  logic [DATA_WIDTH-1:0]    data_output,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     idle
);

  localparam int EW = 1 + HADDR_WIDTH + DATA_WIDTH;
  localparam logic [3:0] TIMEOUT_LAST = 4'(ACK_TIMEOUT - 1);

  typedef struct packed {
    logic                   we;
    logic [HADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]  wdata;
  } entry_t;

  entry_t          push_entry;
  entry_t          head;
  logic [EW-1:0]   fifo_rdata;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;

  state_t                 state_reg, state_next;
  logic [3:0]             timer_reg, timer_next;
  logic                   op_read_reg, op_read_next;
  logic [HADDR_WIDTH-1:0] haddr_reg, haddr_next;
  logic [DATA_WIDTH-1:0]  data_input_reg, data_input_next;
  logic                   rd_en_reg, rd_en_next;
  logic                   wr_en_reg, wr_en_next;
  logic                   rsp_valid_reg, rsp_valid_next;
  logic [DATA_WIDTH-1:0]  rsp_rdata_reg, rsp_rdata_next;

  assign push_entry = '{we: req_we, addr: req_addr, wdata: req_wdata};
  assign head       = entry_t'(fifo_rdata);
  assign req_ready  = !fifo_full;

  sdram_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_valid && req_ready),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (fifo_rdata),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_next      = state_reg;
    timer_next      = timer_reg;
    op_read_next    = op_read_reg;
    haddr_next      = haddr_reg;
    data_input_next = data_input_reg;
    rd_en_next      = 1'b0;
    wr_en_next      = 1'b0;
    rsp_valid_next  = rsp_valid_reg;
    rsp_rdata_next  = rsp_rdata_reg;
    pop             = 1'b0;

    if (rsp_valid_reg && rsp_ready) rsp_valid_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // A read may only go out once the single response slot is free,
        // so a capture can never collide with the host draining it.
        if (!fifo_empty && !busy && (head.we || !rsp_valid_reg)) begin
          pop             = 1'b1;
          state_next      = ST_ISSUE;
          haddr_next      = head.addr;
          data_input_next = head.wdata;
          op_read_next    = !head.we;
          wr_en_next      = head.we;
          rd_en_next      = !head.we;
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT_ACK;
        timer_next = '0;
      end
      ST_WAIT_ACK: begin
        if (busy) begin
          state_next = ST_WAIT_DONE;
        end else if (timer_reg == TIMEOUT_LAST) begin
          // Controller never acknowledged: assume it already finished.
          state_next = ST_IDLE;
          if (op_read_reg) begin
            rsp_rdata_next = data_output;
            rsp_valid_next = 1'b1;
          end
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!busy) begin
          state_next = ST_IDLE;
          if (op_read_reg) begin
            rsp_rdata_next = data_output;
            rsp_valid_next = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      timer_reg      <= '0;
      op_read_reg    <= 1'b0;
      haddr_reg      <= '0;
      data_input_reg <= '0;
      rd_en_reg      <= 1'b0;
      wr_en_reg      <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_rdata_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      op_read_reg    <= op_read_next;
      haddr_reg      <= haddr_next;
      data_input_reg <= data_input_next;
      rd_en_reg      <= rd_en_next;
      wr_en_reg      <= wr_en_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_rdata_reg  <= rsp_rdata_next;
    end
  end

  assign haddr      = haddr_reg;
  assign data_input = data_input_reg;
  assign rd_enable  = rd_en_reg;
  assign wr_enable  = wr_en_reg;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_rdata  = rsp_rdata_reg;
  assign idle       = fifo_empty && (state_reg == ST_IDLE) && !rsp_valid_reg;

endmodule

// File: tb/tb_sdram_host_queue.sv
// Directed bench for sdram_host_queue with a small behavioural controller.
module tb_sdram_host_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [23:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic [23:0] haddr;
  logic [15:0] data_input;
  logic        rd_enable;
  logic        wr_enable;
  logic        busy;
  logic [15:0] data_output;
  logic [2:0]  level;
  logic        idle;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_host_queue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .haddr       (haddr),
    .data_input  (data_input),
    .rd_enable   (rd_enable),
    .wr_enable   (wr_enable),
    .busy        (busy),
    .data_output (data_output),
    .level       (level),
    .idle        (idle)
  );

  // Controller model: raises busy on the edge that sees a strobe and holds
  // it for busy_len cycles; no_ack suppresses it; hold_busy forces it high.
  int   busy_len  = 3;
  bit   no_ack    = 1'b0;
  bit   hold_busy = 1'b0;
  logic mbusy;
  int   mcnt;

  assign busy = mbusy | hold_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mbusy <= 1'b0;
      mcnt  <= 0;
    end else if ((rd_enable || wr_enable) && !no_ack) begin
      mbusy <= 1'b1;
      mcnt  <= busy_len;
    end else if (mbusy) begin
      if (mcnt <= 1) mbusy <= 1'b0;
      else           mcnt  <= mcnt - 1;
    end
  end

  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [15:0] data;
  } log_t;

  log_t log_q[$];
  int   rsp_cyc = 0;

  always @(posedge clk) begin
    if (rst_n && (rd_enable || wr_enable)) begin
      log_q.push_back('{wr_enable, haddr, data_input});
      $display("issue we=%0d addr=0x%06h data=0x%04h", wr_enable, haddr, data_input);
    end
    if (rst_n && rsp_valid) rsp_cyc++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; request is presented for one cycle.
  task automatic push_req(input logic we, input logic [23:0] addr, input logic [15:0] wd);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    $display("push we=%0d addr=0x%06h data=0x%04h ready=%0d", we, addr, wd, req_ready);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!rsp_valid) check_val({tag, "_timeout"}, {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic wait_idle(input string tag, output int cyc);
    cyc = 0;
    while (!idle && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!idle) check_val({tag, "_timeout"}, {31'd0, idle}, 32'd1);
  endtask

  task automatic accept_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_val("rsp_clear", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int cyc;
    int base;
    int rbase;
    int exp_lvl;

    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_we      = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    rsp_ready   = 1'b0;
    data_output = 16'h0000;
    repeat (2) @(negedge clk);

    // Reset state
    check_val("rst_rd_en", {31'd0, rd_enable}, 32'd0);
    check_val("rst_wr_en", {31'd0, wr_enable}, 32'd0);
    check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("rst_haddr", {8'd0, haddr}, 32'd0);
    check_val("rst_data_input", {16'd0, data_input}, 32'd0);
    check_val("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
    check_val("rst_level", {29'd0, level}, 32'd0);
    check_val("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_val("rst_idle", {31'd0, idle}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write
    busy_len = 3;
    base  = log_q.size();
    rbase = rsp_cyc;
    push_req(1'b1, 24'h123456, 16'hBEEF);
    check_val("wr_level", {29'd0, level}, 32'd1);
    check_val("wr_pre_strobe", {31'd0, wr_enable}, 32'd0);
    @(negedge clk);
    check_val("wr_strobe", {31'd0, wr_enable}, 32'd1);
    check_val("wr_no_rd", {31'd0, rd_enable}, 32'd0);
    check_val("wr_haddr", {8'd0, haddr}, 32'h123456);
    check_val("wr_data", {16'd0, data_input}, 32'hBEEF);
    @(negedge clk);
    check_val("wr_strobe_drop", {31'd0, wr_enable}, 32'd0);
    wait_idle("wr_idle", cyc);
    check_val("wr_strobe_count", log_q.size() - base, 32'd1);
    check_val("wr_no_rsp", rsp_cyc - rbase, 32'd0);
    check_val("wr_haddr_hold", {8'd0, haddr}, 32'h123456);

    // Single read with 5-cycle busy
    busy_len    = 5;
    data_output = 16'hA5A5;
    push_req(1'b0, 24'h000010, 16'h0000);
    wait_rsp("rd_rsp", cyc);
    check_val("rd_latency", cyc, 32'd8);
    check_val("rd_data", {16'd0, rsp_rdata}, 32'hA5A5);
    repeat (3) @(negedge clk);
    check_val("rd_hold_valid", {31'd0, rsp_valid}, 32'd1);
    accept_rsp();

    // Fill the FIFO while busy is held
    busy_len  = 2;
    hold_busy = 1'b1;
    base = log_q.size();
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 24'h000100 + 24'(i);
      req_wdata = 16'hC000 + 16'(i);
      $display("push we=1 addr=0x%06h data=0x%04h ready=%0d", req_addr, req_wdata, req_ready);
      @(negedge clk);
      exp_lvl = (i < 4) ? i + 1 : 4;
      check_val("full_level", {29'd0, level}, exp_lvl);
    end
    req_valid = 1'b0;
    check_val("full_ready", {31'd0, req_ready}, 32'd0);
    check_val("full_no_issue", log_q.size() - base, 32'd0);
    hold_busy = 1'b0;
    wait_idle("full_drain", cyc);
    check_val("full_issue_count", log_q.size() - base, 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < log_q.size()) begin
        check_val("full_order_addr", {8'd0, log_q[base+i].addr}, 32'h000100 + i);
        check_val("full_order_data", {16'd0, log_q[base+i].data}, 32'h0000C000 + i);
      end
    end

    // Two reads, response held: second read must wait
    data_output = 16'h1111;
    base = log_q.size();
    push_req(1'b0, 24'h000200, 16'h0000);
    push_req(1'b0, 24'h000201, 16'h0000);
    wait_rsp("rr_first", cyc);
    check_val("rr_first_data", {16'd0, rsp_rdata}, 32'h1111);
    repeat (10) @(negedge clk);
    check_val("rr_withheld", log_q.size() - base, 32'd1);
    check_val("rr_level", {29'd0, level}, 32'd1);
    check_val("rr_still_valid", {31'd0, rsp_valid}, 32'd1);
    data_output = 16'h2222;
    accept_rsp();
    wait_rsp("rr_second", cyc);
    check_val("rr_second_data", {16'd0, rsp_rdata}, 32'h2222);
    check_val("rr_second_issued", log_q.size() - base, 32'd2);
    if (log_q.size() > base + 1)
      check_val("rr_second_addr", {8'd0, log_q[base+1].addr}, 32'h000201);
    accept_rsp();

    // No acknowledge: timeout after 4 cycles in WAIT_ACK
    no_ack = 1'b1;
    push_req(1'b1, 24'h000300, 16'h0F0F);
    wait_idle("to_idle", cyc);
    check_val("to_idle_cycles", cyc, 32'd6);
    data_output = 16'h5A5A;
    base = log_q.size();
    push_req(1'b0, 24'h000301, 16'h0000);
    wait_rsp("to_read", cyc);
    check_val("to_read_issued", log_q.size() - base, 32'd1);
    check_val("to_read_data", {16'd0, rsp_rdata}, 32'h5A5A);
    accept_rsp();
    no_ack = 1'b0;

    // Reset while a strobe is high clears it without waiting for a clock
    busy_len = 3;
    push_req(1'b1, 24'h000500, 16'h5555);
    @(negedge clk);
    check_val("ar_strobe_before", {31'd0, wr_enable}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_val("ar_strobe_async", {31'd0, wr_enable}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset during WAIT_DONE with two requests queued
    busy_len = 8;
    push_req(1'b0, 24'h000400, 16'h0000);
    push_req(1'b1, 24'h000401, 16'h4444);
    push_req(1'b1, 24'h000402, 16'h4545);
    @(negedge clk);
    check_val("rwd_level", {29'd0, level}, 32'd2);
    check_val("rwd_busy", {31'd0, idle}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_val("rwd_rd_en", {31'd0, rd_enable}, 32'd0);
    check_val("rwd_wr_en", {31'd0, wr_enable}, 32'd0);
    check_val("rwd_level0", {29'd0, level}, 32'd0);
    check_val("rwd_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("rwd_idle", {31'd0, idle}, 32'd1);
    check_val("rwd_req_ready", {31'd0, req_ready}, 32'd1);
    check_val("rwd_haddr", {8'd0, haddr}, 32'd0);
    base = log_q.size();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_val("rwd_no_issue", log_q.size() - base, 32'd0);
    check_val("rwd_idle_after", {31'd0, idle}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
